mem_arbiter: RTL and testbench

//  Arbitrates the datapath's instruction-fetch and data-access requests onto a

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-ported RAM.
// Data has priority; a burst counter forces a fetch grant after a bounded data run.
module mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              halt,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ram_req,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = (DATA_BURST_MAX < 1) ? 1 : $clog2(DATA_BURST_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  dcount_q, dcount_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic dreq;
  logic ireq;
  logic dcount_full;

  assign dreq        = dREN | dWEN;
  assign ireq        = iREN & ~halt;
  assign dcount_full = (dcount_q == CNT_W'(DATA_BURST_MAX));

  // State and latched RAM command registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      dcount_q <= '0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      dcount_q <= dcount_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Grant decision in IDLE; bus states wait for the RAM ack
  always_comb begin
    state_d  = state_q;
    dcount_d = dcount_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (dreq && !(ireq && dcount_full)) begin
          state_d = DBUS;
          addr_d  = daddr;
          wdata_d = dstore;
          wen_d   = dWEN;
        end else if (ireq) begin
          state_d  = IBUS;
          addr_d   = iaddr;
          wen_d    = 1'b0;
          dcount_d = '0;
        end
      end
      IBUS: begin
        if (ram_ack) state_d = IDLE;
      end
      DBUS: begin
        if (ram_ack) begin
          state_d = IDLE;
          // Count data grants that made a waiting fetch stand aside
          if (ireq) dcount_d = dcount_full ? dcount_q : dcount_q + CNT_W'(1);
          else      dcount_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_req   = (state_q != IDLE);
  assign ram_wen   = wen_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  assign ihit  = (state_q == IBUS) & ram_ack;
  assign dhit  = (state_q == DBUS) & ram_ack;
  assign iload = ram_rdata;
  assign dload = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable RAM responder.
module tb_mem_arbiter;

  logic        CLK, nRST, halt;
  logic        iREN, ihit;
  logic [31:0] iaddr, iload;
  logic        dREN, dWEN, dhit;
  logic [31:0] daddr, dstore, dload;
  logic        ram_req, ram_wen, ram_ack;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int vectors    = 0;
  int miscompares = 0;
  int lat        = 2;
  int lat_cnt    = 0;

  localparam logic [31:0] RD_MASK = 32'hA5A5_0000;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_BURST_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ram_req(ram_req), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; RAM acks on the (lat+1)th cycle of ram_req, read data = addr ^ mask
  task automatic tick();
    @(posedge CLK);
    #1;
    if (ram_req) lat_cnt++;
    else         lat_cnt = 0;
    ram_ack   = ram_req && (lat_cnt == lat + 1);
    ram_rdata = ram_addr ^ RD_MASK;
    #1;
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!ram_req && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_req_timeout"}, 32'(ram_req), 32'd1);
  endtask

  task automatic wait_hit(input string tag);
    int k = 0;
    while (!(ihit || dhit) && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_hit_timeout"}, 32'(ihit | dhit), 32'd1);
  endtask

  // Bit g of pat set = grant g must be the fetch (0x48), else data (0x84)
  task automatic run_grants(input int n, input logic [15:0] pat, input string tag);
    for (int g = 0; g < n; g++) begin
      wait_req(tag);
      chk($sformatf("%s_grant%0d", tag, g), ram_addr, pat[g] ? 32'h48 : 32'h84);
      wait_hit(tag);
      tick();
    end
  endtask

  initial begin
    int n;
    nRST = 1'b0; halt = 1'b0;
    iREN = 1'b0; iaddr = '0;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ram_ack = 1'b0; ram_rdata = '0;
    #3;
    chk("rst_req",   32'(ram_req), 32'd0);
    chk("rst_ihit",  32'(ihit),    32'd0);
    chk("rst_dhit",  32'(dhit),    32'd0);
    chk("rst_addr",  ram_addr,     32'd0);
    chk("rst_wen",   32'(ram_wen), 32'd0);
    chk("rst_wdata", ram_wdata,    32'd0);
    #9 nRST = 1'b1;
    tick();

    // Idle fetch, ack two cycles after ram_req rises
    lat = 2; iREN = 1'b1; iaddr = 32'h40;
    tick();
    chk("t1_req",  32'(ram_req), 32'd1);
    chk("t1_wen",  32'(ram_wen), 32'd0);
    chk("t1_addr", ram_addr,     32'h40);
    chk("t1_c1_ihit", 32'(ihit), 32'd0);
    tick();
    chk("t1_c2_ihit", 32'(ihit), 32'd0);
    tick();
    chk("t1_c3_ihit", 32'(ihit), 32'd1);
    chk("t1_iload",   iload,     32'hA5A5_0040);
    iREN = 1'b0;
    tick();
    chk("t1_idle_req", 32'(ram_req), 32'd0);

    // Collision: data first, fetch two cycles after dhit
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h80;
    tick();
    chk("t2_daddr", ram_addr, 32'h80);
    tick();
    tick();
    chk("t2_dhit",  32'(dhit), 32'd1);
    chk("t2_noihit", 32'(ihit), 32'd0);
    chk("t2_dload", dload,     32'hA5A5_0080);
    dREN = 1'b0;
    tick();
    chk("t2_gap_req", 32'(ram_req), 32'd0);
    tick();
    chk("t2_ireq",  32'(ram_req), 32'd1);
    chk("t2_iaddr", ram_addr,     32'h44);
    tick();
    tick();
    chk("t2_ihit", 32'(ihit), 32'd1);
    iREN = 1'b0;
    tick();

    // Starvation: D,D,D,D,I,D,D,D,D,I
    lat = 1; iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h84;
    run_grants(10, 16'h0210, "t3");
    iREN = 1'b0; dREN = 1'b0;
    tick();

    // Halt blocks fetch grants; in-flight fetch completes once
    lat = 2; halt = 1'b1; iREN = 1'b1; iaddr = 32'h4C;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ram_req) n++;
    end
    chk("t4_halt_req_cycles", 32'(n), 32'd0);
    halt = 1'b0;
    tick();
    chk("t4_req",  32'(ram_req), 32'd1);
    chk("t4_addr", ram_addr,     32'h4C);
    halt = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ihit) begin
        n++;
        chk("t4_iload", iload, 32'hA5A5_004C);
      end
    end
    chk("t4_ihit_count", 32'(n), 32'd1);
    chk("t4_end_req", 32'(ram_req), 32'd0);
    iREN = 1'b0; halt = 1'b0;
    tick();

    // Write holds latched command while requester inputs change
    lat = 3; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    tick();
    daddr = 32'h200; dstore = 32'h1234_5678;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (ram_req) begin
        chk("t5_addr",  ram_addr,     32'h100);
        chk("t5_wdata", ram_wdata,    32'hDEAD_BEEF);
        chk("t5_wen",   32'(ram_wen), 32'd1);
      end
      if (dhit) begin
        n++;
        dWEN = 1'b0;
      end
      tick();
    end
    chk("t5_dhit_count", 32'(n), 32'd1);
    daddr = '0; dstore = '0;
    tick();

    // Reset mid-DBUS with burst counter at 3; counter must restart from 0
    lat = 0; iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h84;
    run_grants(3, 16'h0000, "t6pre");
    lat = 5;
    wait_req("t6_inflight");
    chk("t6_inflight_addr", ram_addr, 32'h84);
    #1 nRST = 1'b0;
    #1;
    chk("t6_async_req",  32'(ram_req), 32'd0);
    chk("t6_async_dhit", 32'(dhit),    32'd0);
    chk("t6_async_addr", ram_addr,     32'd0);
    tick();
    chk("t6_held_req", 32'(ram_req), 32'd0);
    nRST = 1'b1;
    lat = 0; lat_cnt = 0; ram_ack = 1'b0;
    run_grants(5, 16'h0010, "t6post");
    iREN = 1'b0; dREN = 1'b0;
    tick();
    chk("t6_final_req", 32'(ram_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
